alu_lockstep_checker: RTL and testbench
=======================================

ALU_LOCKSTEP_CHECKER -- requirements
Module: alu_lockstep_checker

Interface
REQ-001 Parameter WIDTH, default 16, data width of A, B and S; legal range 4..27.
REQ-002 Parameter NVEC_W, default 20, width of vector-count registers; run length up to 2^NVEC_W-1.
REQ-003 Parameter SEED, default 64'h0000_0000_0000_ACE1, LFSR load value; must be nonzero.
REQ-004 clk  in  1  system clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  single-cycle pulse; begins a run when idle.
REQ-007 num_vec  in  NVEC_W  vectors to apply; sampled on accepted start.
REQ-008 fix_op_en  in  1  1 = hold opcode/opext at fix_op for the whole run.
REQ-009 fix_op  in  8  {opcode, opext} used when fix_op_en=1; sampled on start.
REQ-010 A, B  out  WIDTH  operands driven to both ALUs.
REQ-011 opcode, opext  out  4 each  operation select to both ALUs.
REQ-012 carry  out  1  carry-in to both ALUs.
REQ-013 S1, S2  in  WIDTH  results of reference ALU and ALU under test.
REQ-014 CLFZN1, CLFZN2  in  5 each  flags of reference ALU and ALU under test.
REQ-015 busy  out  1  high while running.
REQ-016 done  out  1  single-cycle pulse at run end.
REQ-017 pass  out  1  1 when last run had zero mismatches; valid from done until next start.
REQ-018 err_count  out  NVEC_W  mismatch count, saturating at all-ones.
REQ-019 first_err_vec  out  2*WIDTH+9  {A,B,opcode,opext,carry} of first mismatching vector.
REQ-020 first_err_idx  out  NVEC_W  zero-based index of first mismatching vector.

Function
REQ-021 FSM states IDLE, RUN, DONE; IDLE->RUN on start with num_vec!=0; RUN->DONE when final vector compared; DONE->IDLE unconditionally next cycle.
REQ-022 start with num_vec=0 in IDLE: go directly to DONE, pass=1, err_count=0.
REQ-023 start while busy or in DONE is ignored.
REQ-024 Stimulus source: 64-bit Fibonacci LFSR, taps 64,63,61,60, advanced once per RUN cycle; loaded with SEED on reset only, so consecutive runs continue the sequence.
REQ-025 Stimulus mapping from LFSR bits [2*WIDTH+8:0]: A=top WIDTH, B=next WIDTH, opcode, opext, carry=bit 0; opcode/opext replaced by fix_op when fix_op_en latched high.
REQ-026 Stimulus outputs are registers; vector k is driven for exactly one cycle, ALUs are combinational, compare of vector k sampled at the edge ending that cycle.
REQ-027 Mismatch: S1!=S2 or CLFZN1!=CLFZN2; X/Z on any compared input counts as mismatch.
REQ-028 err_count increments one cycle after the mismatching vector is presented; saturates, never wraps.
REQ-029 first_err_vec/first_err_idx load only on first mismatch of a run; cleared to 0 on accepted start.
REQ-030 done asserts exactly num_vec+1 cycles after the accepted start edge; busy high for num_vec cycles.
REQ-031 Between runs, stimulus outputs hold last vector; err_count/pass hold until next accepted start.

Reset
REQ-032 reset forces IDLE, LFSR=SEED, A=B=opcode=opext=carry=0, busy=done=pass=0, err_count=first_err_idx=first_err_vec=0.
REQ-033 reset mid-run aborts without done pulse; reset dominates start in the same cycle.

Structure
REQ-034 Shared package holds FSM state encoding, LFSR tap constant, and stimulus-field offset constants.
REQ-035 One sub-module lfsr64 (load, advance, 64-bit state); remainder in the top module.

Verification
REQ-036 Identical ALUs, num_vec=1000 -> done at cycle 1001 after start, pass=1, err_count=0.
REQ-037 UUT with S bit 0 inverted when opcode=4'h5, fix_op_en=1 fix_op=8'h50, num_vec=10 -> err_count=10, first_err_idx=0, pass=0.
REQ-038 UUT flag error injected only at vector index 7 -> err_count=1, first_err_idx=7, first_err_vec equals vector driven in run cycle 7.
REQ-039 NVEC_W=4, always-mismatching UUT, num_vec=15 -> err_count=15 (all-ones), no wrap; start during busy ignored.
REQ-040 Reset asserted at run cycle 5 of 20 -> no done, all outputs at reset values next cycle; next run reproduces SEED sequence from vector 0.

Source files
------------

// File: rtl/alu_lockstep_checker_pkg.sv
// rtl/alu_lockstep_checker_pkg.sv - shared FSM encoding, LFSR taps and stimulus field offsets
package alu_lockstep_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Fibonacci taps 64,63,61,60 expressed as a mask over state bits [63:0]
  localparam logic [63:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

  // Stimulus word layout from LSB: carry, opext, opcode, B, then A on top
  localparam int CARRY_BIT  = 0;
  localparam int OPEXT_LSB  = 1;
  localparam int OPCODE_LSB = 5;
  localparam int B_LSB      = 9;

endpackage

// File: rtl/alu_lockstep_checker_lfsr64.sv
// rtl/alu_lockstep_checker_lfsr64.sv - 64-bit Fibonacci LFSR with seed load and advance
module lfsr64
  import alu_lockstep_checker_pkg::*;
#(
  parameter logic [63:0] SEED = 64'h0000_0000_0000_ACE1
) (
  input  logic        clk,
  input  logic        load,
  input  logic        advance,
  output logic [63:0] state,
  output logic [63:0] state_next
);

  always_comb state_next = {state[62:0], ^(state & LFSR_TAPS)};

  always_ff @(posedge clk) begin
    if (load) begin
      state <= SEED;
    end else if (advance) begin
      state <= state_next;
    end
  end

endmodule

// File: rtl/alu_lockstep_checker.sv
// rtl/alu_lockstep_checker.sv - drives LFSR vectors into two ALUs and compares their results
module alu_lockstep_checker
  import alu_lockstep_checker_pkg::*;
#(
  parameter int          WIDTH  = 16,
  parameter int          NVEC_W = 20,
  parameter logic [63:0] SEED   = 64'h0000_0000_0000_ACE1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [NVEC_W-1:0]    num_vec,
  input  logic                 fix_op_en,
  input  logic [7:0]           fix_op,
  output logic [WIDTH-1:0]     A,
  output logic [WIDTH-1:0]     B,
  output logic [3:0]           opcode,
  output logic [3:0]           opext,
  output logic                 carry,
  input  logic [WIDTH-1:0]     S1,
  input  logic [WIDTH-1:0]     S2,
  input  logic [4:0]           CLFZN1,
  input  logic [4:0]           CLFZN2,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [NVEC_W-1:0]    err_count,
  output logic [2*WIDTH+8:0]   first_err_vec,
  output logic [NVEC_W-1:0]    first_err_idx
);

  localparam int VEC_W = 2*WIDTH + 9;
  localparam logic [NVEC_W-1:0] ONE = NVEC_W'(1);

  state_t             state, state_nxt;
  logic [VEC_W-1:0]   vec_q;
  logic [NVEC_W-1:0]  num_vec_q, idx_q;
  logic               fix_en_q;
  logic [7:0]         fix_op_q;
  logic [63:0]        lfsr_state, lfsr_next;
  logic [VEC_W-1:0]   lfsr_vec, lfsr_next_vec;
  logic               accept, last, mismatch, advance;

  function automatic logic [VEC_W-1:0] map_vec(input logic [VEC_W-1:0] raw,
                                               input logic fen, input logic [7:0] fop);
    logic [VEC_W-1:0] v;
    v = raw;
    if (fen) v[OPEXT_LSB +: 8] = fop;
    return v;
  endfunction

  assign accept  = (state == ST_IDLE) && start;
  assign last    = (idx_q == num_vec_q - ONE);
  assign advance = (state == ST_RUN);

  lfsr64 #(.SEED(SEED)) u_lfsr (
    .clk        (clk),
    .load       (reset),
    .advance    (advance),
    .state      (lfsr_state),
    .state_next (lfsr_next)
  );

  assign lfsr_vec      = VEC_W'(lfsr_state);
  assign lfsr_next_vec = VEC_W'(lfsr_next);

  // Any unknown on the compared buses falls through to the mismatch branch
  always_comb begin
    mismatch = 1'b1;
    if ((S1 == S2) && (CLFZN1 == CLFZN2)) mismatch = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = (num_vec == '0) ? ST_DONE : ST_RUN;
      ST_RUN:  if (last)  state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == ST_RUN);
    done = (state == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vec_q         <= '0;
      num_vec_q     <= '0;
      idx_q         <= '0;
      fix_en_q      <= 1'b0;
      fix_op_q      <= '0;
      pass          <= 1'b0;
      err_count     <= '0;
      first_err_vec <= '0;
      first_err_idx <= '0;
    end else if (accept) begin
      num_vec_q     <= num_vec;
      fix_en_q      <= fix_op_en;
      fix_op_q      <= fix_op;
      idx_q         <= '0;
      err_count     <= '0;
      first_err_vec <= '0;
      first_err_idx <= '0;
      pass          <= (num_vec == '0);
      if (num_vec != '0) vec_q <= map_vec(lfsr_vec, fix_op_en, fix_op);
    end else if (state == ST_RUN) begin
      idx_q <= idx_q + ONE;
      if (mismatch) begin
        if (err_count != '1) err_count <= err_count + ONE;
        if (err_count == '0) begin
          first_err_vec <= vec_q;
          first_err_idx <= idx_q;
        end
      end
      // The final vector stays on the outputs until the next run
      if (last) pass  <= !mismatch && (err_count == '0);
      else      vec_q <= map_vec(lfsr_next_vec, fix_en_q, fix_op_q);
    end
  end

  assign A      = vec_q[VEC_W-1 -: WIDTH];
  assign B      = vec_q[B_LSB +: WIDTH];
  assign opcode = vec_q[OPCODE_LSB +: 4];
  assign opext  = vec_q[OPEXT_LSB +: 4];
  assign carry  = vec_q[CARRY_BIT];

endmodule

// File: tb/tb_alu_lockstep_checker.sv
// tb/tb_alu_lockstep_checker.sv - self-checking bench for alu_lockstep_checker
module tb_alu_lockstep_checker;

  localparam int          W    = 16;
  localparam int          NW   = 20;
  localparam int          VW   = 2*W + 9;
  localparam logic [63:0] SEED = 64'h0000_0000_0000_ACE1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, start, fen;
  logic [NW-1:0] num_vec;
  logic [7:0]    fop;
  logic [W-1:0]  A, B, S1, S2;
  logic [3:0]    opcode, opext;
  logic          carry, busy, done, pass;
  logic [4:0]    F1, F2;
  logic [NW-1:0] err_count, first_err_idx;
  logic [VW-1:0] first_err_vec;

  logic          start4;
  logic [3:0]    nv4;
  logic [W-1:0]  A4, B4, S1_4, S2_4;
  logic [3:0]    opcode4, opext4;
  logic          carry4, busy4, done4, pass4;
  logic [4:0]    F1_4, F2_4;
  logic [3:0]    err4, fidx4;
  logic [VW-1:0] fvec4;

  int            n_cmp = 0;
  int            n_bad = 0;
  int            md = 0;
  logic [VW-1:0] target = '1;
  logic [63:0]   m_lfsr = SEED;

  alu_lockstep_checker #(.WIDTH(W), .NVEC_W(NW), .SEED(SEED)) dut (
    .clk(clk), .reset(reset), .start(start), .num_vec(num_vec), .fix_op_en(fen), .fix_op(fop),
    .A(A), .B(B), .opcode(opcode), .opext(opext), .carry(carry),
    .S1(S1), .S2(S2), .CLFZN1(F1), .CLFZN2(F2),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_vec(first_err_vec), .first_err_idx(first_err_idx));

  alu_lockstep_checker #(.WIDTH(W), .NVEC_W(4), .SEED(SEED)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .num_vec(nv4), .fix_op_en(1'b0), .fix_op(8'h00),
    .A(A4), .B(B4), .opcode(opcode4), .opext(opext4), .carry(carry4),
    .S1(S1_4), .S2(S2_4), .CLFZN1(F1_4), .CLFZN2(F2_4),
    .busy(busy4), .done(done4), .pass(pass4), .err_count(err4),
    .first_err_vec(fvec4), .first_err_idx(fidx4));

  function automatic logic [W+4:0] ref_alu(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [3:0] op, input logic [3:0] ext, input logic c);
    logic [W:0]   sum;
    logic [W-1:0] s;
    sum = {1'b0, a} + {1'b0, b ^ {(W/4){ext}}} + {{W{1'b0}}, c};
    s   = sum[W-1:0] ^ {op, {(W-4){1'b0}}};
    return {s, sum[W], op[1], c, (s == '0), s[W-1]};
  endfunction

  // Fault rules for the unit under test, as a function of the vector it sees
  function automatic logic mm_rule(input logic [VW-1:0] v, input int m, input logic [VW-1:0] tgt);
    logic [W-1:0] a;
    a = v[VW-1 -: W];
    case (m)
      1:       return v[8:5] == 4'h5;
      2:       return v == tgt;
      3:       return a[1:0] == 2'b11;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [63:0] lfsr_step(input logic [63:0] s);
    return {s[62:0], s[63] ^ s[62] ^ s[60] ^ s[59]};
  endfunction

  function automatic logic [VW-1:0] field_of(input logic [63:0] s, input logic e, input logic [7:0] f);
    logic [W-1:0] a, b;
    logic [3:0]   op, ext;
    a   = s[2*W+8 -: W];
    b   = s[W+8 -: W];
    op  = e ? f[7:4] : s[8:5];
    ext = e ? f[3:0] : s[4:1];
    return {a, b, op, ext, s[0]};
  endfunction

  logic inj;
  always_comb begin
    {S1, F1} = ref_alu(A, B, opcode, opext, carry);
    inj      = mm_rule({A, B, opcode, opext, carry}, md, target);
    S2       = S1 ^ {{(W-1){1'b0}}, (inj && (md != 2))};
    F2       = F1 ^ {4'b0000, (inj && (md == 2))};
    {S1_4, F1_4} = ref_alu(A4, B4, opcode4, opext4, carry4);
    S2_4     = ~S1_4;
    F2_4     = F1_4;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_main(input int n, input logic e, input logic [7:0] f, input int m,
                          input bit use_tab, input int terr, input int tidx, input logic tpass);
    logic [VW-1:0] vq[$];
    logic [63:0]   L;
    int            cnt, fidx, run_cnt, xerr, xidx;
    logic [VW-1:0] fvec;
    logic          xpass;
    L = m_lfsr;
    for (int k = 0; k < n; k++) begin
      vq.push_back(field_of(L, e, f));
      L = lfsr_step(L);
    end
    md     = m;
    target = (m == 2 && n > 7) ? vq[7] : '1;
    cnt = 0; fidx = 0; fvec = '0;
    for (int k = 0; k < n; k++) begin
      if (mm_rule(vq[k], m, target)) begin
        if (cnt == 0) begin fidx = k; fvec = vq[k]; end
        cnt++;
      end
    end
    xerr  = use_tab ? terr  : cnt;
    xidx  = use_tab ? tidx  : fidx;
    xpass = use_tab ? tpass : (cnt == 0);

    @(negedge clk);
    num_vec = NW'(n); fen = e; fop = f; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; fen = ~e; fop = ~f; num_vec = NW'(n + 3);
    run_cnt = 0;
    for (int c = 1; c <= n + 1; c++) begin
      @(negedge clk);
      if (c <= n) begin
        check("cyc_vec", {A, B, opcode, opext, carry}, vq[c-1]);
        check("cyc_ctl", {busy, done, err_count}, {2'b10, NW'(run_cnt)});
        if (mm_rule(vq[c-1], m, target)) run_cnt++;
      end else begin
        check("done_ctl", {busy, done}, 2'b01);
        check("err_count", err_count, xerr);
        check("pass", pass, xpass);
        check("first_err_idx", first_err_idx, xidx);
        check("first_err_vec", first_err_vec, fvec);
      end
    end
    m_lfsr = L;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("post_done", {busy, done, pass, err_count}, {2'b00, xpass, NW'(xerr)});
    if (n > 0) check("hold_vec", {A, B, opcode, opext, carry}, vq[n-1]);
  endtask

  typedef struct {
    int         n;
    logic       e;
    logic [7:0] f;
    int         m;
    int         err;
    int         idx;
    logic       pass;
  } row_t;
  row_t tab[6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   done_at, busy_cnt, e4;
    logic seen;
    tab[0] = '{1000, 1'b0, 8'h00, 0, 0,  0, 1'b1};
    tab[1] = '{10,   1'b1, 8'h50, 1, 10, 0, 1'b0};
    tab[2] = '{30,   1'b0, 8'h00, 2, 1,  7, 1'b0};
    tab[3] = '{0,    1'b0, 8'h00, 0, 0,  0, 1'b1};
    tab[4] = '{1,    1'b1, 8'h5A, 1, 1,  0, 1'b0};
    tab[5] = '{2,    1'b0, 8'h00, 0, 0,  0, 1'b1};

    reset = 1'b1; start = 1'b0; fen = 1'b0; fop = '0; num_vec = '0;
    start4 = 1'b0; nv4 = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_state", {A, B, opcode, opext, carry, busy, done, pass, err_count, first_err_idx, first_err_vec}, '0);

    foreach (tab[i])
      run_main(tab[i].n, tab[i].e, tab[i].f, tab[i].m, 1'b1, tab[i].err, tab[i].idx, tab[i].pass);

    for (int r = 0; r < 8; r++) begin
      int n, m;
      n = $urandom_range(1, 60);
      m = $urandom_range(0, 3);
      if (m == 2 && n <= 7) m = 0;
      run_main(n, 1'($urandom_range(0, 1)), 8'($urandom), m, 1'b0, 0, 0, 1'b0);
    end

    // Reset in the middle of a run, then confirm the sequence restarts from the seed
    md = 3;
    @(negedge clk);
    num_vec = NW'(20); fen = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_mid_run", {A, B, opcode, opext, carry, busy, done, pass, err_count, first_err_idx, first_err_vec}, '0);
    m_lfsr = SEED;
    seen = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("no_done_after_abort", seen, 1'b0);
    run_main(5, 1'b0, 8'h00, 0, 1'b0, 0, 0, 1'b0);

    // Narrow counter, always-mismatching unit, start pulse while busy
    @(negedge clk);
    nv4 = 4'd15; start4 = 1'b1;
    @(posedge clk);
    #1 start4 = 1'b0;
    done_at = 0; busy_cnt = 0; e4 = -1;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      start4 = (c == 5);
      if (c == 5) nv4 = 4'd3;
      busy_cnt += int'(busy4);
      if (done4 && done_at == 0) begin
        done_at = c;
        e4 = int'(err4);
        check("sat_pass", pass4, 1'b0);
        check("sat_first_idx", fidx4, 4'd0);
      end
    end
    start4 = 1'b0;
    check("sat_done_cycle", done_at, 16);
    check("sat_busy_cycles", busy_cnt, 15);
    check("sat_err_count", e4, 15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
